// File: rtl/dram_cmd_timer_pkg.sv
// Shared DRAM command/bank-state encodings, default timings and counter helpers
// used by dram_cmd_timer and its per-bank timer.
package dram_cmd_timer_pkg;

    typedef enum logic [1:0] {
        CMD_ACT   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_PRE   = 2'b11
    } dram_cmd_e;

    typedef enum logic [1:0] {
        BANK_CLOSED      = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_OPEN        = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_EVAL = 2'd1,
        FSM_ACK  = 2'd2,
        FSM_DROP = 2'd3
    } ctrl_state_e;

    localparam int DEF_T_RCD = 3;
    localparam int DEF_T_RP  = 3;
    localparam int DEF_T_RAS = 5;
    localparam int DEF_T_CL  = 2;

    // Timing values are limited to 1..15, so a 4-bit down-counter suffices.
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// Per-bank state machine with open-row storage, tRAS and phase (tRCD/tRP)
// down-counters; counters run every cycle and saturate at zero.
module dram_bank_timer
    import dram_cmd_timer_pkg::*;
#(
    parameter int ROW_W = 7,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RAS = DEF_T_RAS
)(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             act_i,
    input  logic             pre_i,
    input  logic [ROW_W-1:0] row_i,
    output logic [1:0]       state_o,
    output logic [ROW_W-1:0] row_o,
    output logic             tras_zero_o,
    output logic             phase_zero_o
);

    bank_state_e      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] tras_q, tras_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        phase_d = cnt_dec(phase_q);
        tras_d  = cnt_dec(tras_q);

        if (phase_q == '0) begin
            if (state_q == BANK_ACTIVATING) begin
                state_d = BANK_OPEN;
            end else if (state_q == BANK_PRECHARGING) begin
                state_d = BANK_CLOSED;
            end
        end

        if (act_i) begin
            state_d = BANK_ACTIVATING;
            phase_d = CNT_W'(T_RCD - 1);
            tras_d  = CNT_W'(T_RAS - 1);
            row_d   = row_i;
        end else if (pre_i) begin
            state_d = BANK_PRECHARGING;
            phase_d = CNT_W'(T_RP - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= BANK_CLOSED;
            row_q   <= '0;
            phase_q <= '0;
            tras_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            tras_q  <= tras_d;
        end
    end

    assign state_o      = state_q;
    assign row_o        = row_q;
    assign tras_zero_o  = (tras_q == '0);
    assign phase_zero_o = (phase_q == '0);

endmodule

// File: rtl/dram_cmd_timer.sv
// DRAM command timing checker: req/ack handshake FSM, per-bank timers and a
// T_CL-deep read-data pipeline. Define DRAM_CMD_TIMER_ERR_EN to add cmd_err.
module dram_cmd_timer
    import dram_cmd_timer_pkg::*;
#(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_CL         = DEF_T_CL,
    localparam int BANK_W      = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int ROW_W       = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1
)(
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    output logic                    cmd_ack,
    output logic [NUM_OF_BANKS-1:0] bank_open,
    output logic                    rd_valid,
    output logic [BANK_W-1:0]       rd_bank
`ifdef DRAM_CMD_TIMER_ERR_EN
    ,
    output logic                    cmd_err
`endif
);

    ctrl_state_e state_q, state_d;

    logic [1:0]              bank_state [NUM_OF_BANKS];
    logic [ROW_W-1:0]        bank_row   [NUM_OF_BANKS];
    logic [NUM_OF_BANKS-1:0] tras_zero;
    logic [NUM_OF_BANKS-1:0] phase_zero;
    logic [NUM_OF_BANKS-1:0] act_vec;
    logic [NUM_OF_BANKS-1:0] pre_vec;

    logic [BANK_W-1:0] bank_idx;
    logic [ROW_W-1:0]  row_idx;
    bank_state_e       sel_state;
    logic [ROW_W-1:0]  sel_row;
    logic              sel_tras0;
    logic              sel_ph0;
    logic              bank_oh, row_oh, col_oh;

    logic illegal, ready, noop;
    logic grant, exec;

    logic              ack_rd_q, ack_rd_d;
    logic [BANK_W-1:0] ack_bank_q, ack_bank_d;

    logic [T_CL-1:0]             rd_vld_q;
    logic [T_CL-1:0][BANK_W-1:0] rd_bnk_q;

    for (genvar g = 0; g < NUM_OF_BANKS; g++) begin : g_bank
        dram_bank_timer #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_bank (
            .clk          (clk),
            .rst_b        (rst_b),
            .act_i        (act_vec[g]),
            .pre_i        (pre_vec[g]),
            .row_i        (row_idx),
            .state_o      (bank_state[g]),
            .row_o        (bank_row[g]),
            .tras_zero_o  (tras_zero[g]),
            .phase_zero_o (phase_zero[g])
        );
        assign bank_open[g] = (bank_state[g] == BANK_OPEN);
    end

    // One-hot to index; only meaningful when the select is actually one-hot.
    always_comb begin
        bank_idx = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            if (bank_sel[i]) bank_idx = BANK_W'(i);
        end
        row_idx = '0;
        for (int i = 0; i < NUM_OF_ROWS; i++) begin
            if (row_sel[i]) row_idx = ROW_W'(i);
        end
    end

    assign bank_oh   = $onehot(bank_sel);
    assign row_oh    = $onehot(row_sel);
    assign col_oh    = $onehot(col_sel);
    assign sel_state = bank_state_e'(bank_state[bank_idx]);
    assign sel_row   = bank_row[bank_idx];
    assign sel_tras0 = tras_zero[bank_idx];
    assign sel_ph0   = phase_zero[bank_idx];

    // A bank whose phase counter is at zero changes state at the same edge the
    // command would execute, so it is already treated as ready.
    always_comb begin
        illegal = 1'b0;
        ready   = 1'b0;
        noop    = 1'b0;
        case (cmd)
            CMD_ACT: begin
                illegal = !bank_oh || !row_oh ||
                          (sel_state == BANK_ACTIVATING) || (sel_state == BANK_OPEN);
                ready   = (sel_state == BANK_CLOSED) ||
                          ((sel_state == BANK_PRECHARGING) && sel_ph0);
            end
            CMD_READ, CMD_WRITE: begin
                illegal = !bank_oh || !row_oh || !col_oh ||
                          (sel_state == BANK_CLOSED) || (sel_state == BANK_PRECHARGING) ||
                          (sel_row != row_idx);
                ready   = (sel_state == BANK_OPEN) ||
                          ((sel_state == BANK_ACTIVATING) && sel_ph0);
            end
            default: begin
                illegal = !bank_oh;
                noop    = (sel_state == BANK_CLOSED) || (sel_state == BANK_PRECHARGING);
                ready   = noop || sel_tras0;
            end
        endcase
    end

    assign grant = (state_q == FSM_EVAL) && cmd_req && (illegal || ready);
    assign exec  = grant && !illegal && !noop;

    assign act_vec    = (exec && (cmd == CMD_ACT)) ? bank_sel : '0;
    assign pre_vec    = (exec && (cmd == CMD_PRE)) ? bank_sel : '0;
    assign ack_rd_d   = exec && (cmd == CMD_READ);
    assign ack_bank_d = bank_idx;

    always_comb begin
        state_d = state_q;
        cmd_ack = 1'b0;
        case (state_q)
            FSM_IDLE: if (cmd_req) state_d = FSM_EVAL;
            FSM_EVAL: begin
                if (!cmd_req) begin
                    state_d = FSM_IDLE;
                end else if (grant) begin
                    state_d = FSM_ACK;
                end
            end
            FSM_ACK: begin
                cmd_ack = 1'b1;
                state_d = FSM_DROP;
            end
            FSM_DROP: if (!cmd_req) state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= FSM_IDLE;
            ack_rd_q   <= 1'b0;
            ack_bank_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_rd_q   <= ack_rd_d;
            ack_bank_q <= ack_bank_d;
        end
    end

    // Read pipeline is fed from the ACK cycle, giving rd_valid T_CL cycles later.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_vld_q <= '0;
            rd_bnk_q <= '0;
        end else begin
            rd_vld_q[0] <= ack_rd_q;
            rd_bnk_q[0] <= ack_rd_q ? ack_bank_q : '0;
            for (int i = 1; i < T_CL; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_bnk_q[i] <= rd_bnk_q[i-1];
            end
        end
    end

    assign rd_valid = rd_vld_q[T_CL-1];
    assign rd_bank  = rd_bnk_q[T_CL-1];

`ifdef DRAM_CMD_TIMER_ERR_EN
    logic err_q, err_d;

    assign err_d = grant && illegal;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cmd_err = err_q;
`endif

endmodule
